random_word_harvester: RTL and testbench

Consumer side of the iCE40 entropy sources: samples a free-running metastable bit, such as the output of `metastable_oscillator_depth2`, into the system clock domain. It removes bias with a von Neumann extractor, packs the accepted bits into words and offers them on a valid/ready port. A sticky repetition-count health check blocks output when the source sticks.

---
 rtl/random_word_harvester_pkg.sv | 9 +
 rtl/von_neumann_debiaser.sv | 38 +++
 rtl/random_word_harvester.sv | 134 +++++++++++++
 tb/tb_random_word_harvester.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/random_word_harvester_pkg.sv
// Shared types for the random word harvester: debiaser pair-phase encoding.
package random_word_harvester_pkg;

    typedef enum logic {
        ST_FIRST  = 1'b0,
        ST_SECOND = 1'b1
    } deb_state_t;

endpackage

// File: rtl/von_neumann_debiaser.sv
// Von Neumann extractor: consumes raw bits in pairs, emits the first bit of every unequal pair.
//
// state     | meaning
// ST_FIRST  | waiting for the first bit of a pair
// ST_SECOND | holding bit a, next enabled bit completes the pair
module von_neumann_debiaser
    import random_word_harvester_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    input  logic in_bit,
    output logic out_valid,
    output logic out_bit
);

    deb_state_t state;
    logic       bit_a;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_FIRST;
            bit_a <= 1'b0;
        end else if (enable) begin
            if (state == ST_FIRST) begin
                bit_a <= in_bit;
                state <= ST_SECOND;
            end else begin
                state <= ST_FIRST;
            end
        end
    end

    // Emission is decided on the completing tick so the packer can take the bit on that same edge.
    assign out_valid = enable && (state == ST_SECOND) && (bit_a != in_bit);
    assign out_bit   = bit_a;

endmodule

// File: rtl/random_word_harvester.sv
// Samples an asynchronous entropy bit, debiases it, packs accepted bits into words
// and offers them on a valid/ready port, guarded by a sticky repetition-count check.
module random_word_harvester
    import random_word_harvester_pkg::*;
#(
    parameter int WORD_WIDTH     = 32,
    parameter int SAMPLE_DIVIDER = 4,
    parameter int REPEAT_LIMIT   = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  metastable,
    output logic [WORD_WIDTH-1:0] word,
    output logic                  word_valid,
    input  logic                  word_ready,
    output logic                  health_fail
);

    localparam int DIV_W = (SAMPLE_DIVIDER > 1) ? $clog2(SAMPLE_DIVIDER) : 1;
    localparam int BIT_W = $clog2(WORD_WIDTH + 1);
    localparam int REP_W = $clog2(REPEAT_LIMIT + 1);

    localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(SAMPLE_DIVIDER - 1);
    localparam logic [BIT_W-1:0] BIT_FULL = BIT_W'(WORD_WIDTH);
    localparam logic [BIT_W-1:0] BIT_ONE  = BIT_W'(1);
    localparam logic [REP_W-1:0] REP_MAX  = REP_W'(REPEAT_LIMIT);
    localparam logic [REP_W-1:0] REP_ONE  = REP_W'(1);

    logic                  sync0;
    logic                  sync1;
    logic [DIV_W-1:0]      div_cnt;
    logic                  tick;
    logic                  prev_sample;
    logic [REP_W-1:0]      rep_cnt;
    logic [REP_W-1:0]      rep_next;
    logic                  trip;
    logic                  fail;
    logic [WORD_WIDTH-1:0] shreg;
    logic [BIT_W-1:0]      bit_cnt;
    logic                  full;
    logic                  transfer;
    logic                  stall;
    logic                  enable;
    logic                  emit_valid;
    logic                  emit_bit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync0 <= 1'b0;
            sync1 <= 1'b0;
        end else begin
            sync0 <= metastable;
            sync1 <= sync0;
        end
    end

    // Down-counter loaded with SAMPLE_DIVIDER-1 so the first tick lands SAMPLE_DIVIDER-1 cycles after reset.
    assign tick = (div_cnt == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            div_cnt <= DIV_LOAD;
        else if (tick)
            div_cnt <= DIV_LOAD;
        else
            div_cnt <= div_cnt - 1'b1;
    end

    always_comb begin
        rep_next = REP_ONE;
        if (sync1 == prev_sample)
            rep_next = (rep_cnt == REP_MAX) ? rep_cnt : rep_cnt + 1'b1;
    end

    assign trip = tick && (rep_next == REP_MAX);
    assign fail = health_fail || trip;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_sample <= 1'b0;
            rep_cnt     <= '0;
            health_fail <= 1'b0;
        end else if (tick) begin
            prev_sample <= sync1;
            rep_cnt     <= rep_next;
            if (trip)
                health_fail <= 1'b1;
        end
    end

    assign full     = (bit_cnt == BIT_FULL);
    assign transfer = full && (!word_valid || word_ready) && !fail;
    assign stall    = full && !transfer;
    assign enable   = tick && !stall && !fail;

    von_neumann_debiaser u_debiaser (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .in_bit    (sync1),
        .out_valid (emit_valid),
        .out_bit   (emit_bit)
    );

    // A bit may arrive on the same edge the full register drains, so it seeds the next word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg   <= '0;
            bit_cnt <= '0;
        end else begin
            if (emit_valid)
                shreg <= {shreg[WORD_WIDTH-2:0], emit_bit};
            if (transfer)
                bit_cnt <= emit_valid ? BIT_ONE : '0;
            else if (emit_valid)
                bit_cnt <= bit_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word       <= '0;
            word_valid <= 1'b0;
        end else if (fail) begin
            word_valid <= 1'b0;
        end else if (transfer) begin
            word       <= shreg;
            word_valid <= 1'b1;
        end else if (word_valid && word_ready) begin
            word_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_random_word_harvester.sv
// Directed bench for random_word_harvester: one raw bit is driven per clock on the falling edge.
module tb_random_word_harvester;

    logic       clk;
    logic       rst_n;
    logic       metastable;
    logic       word_ready;
    logic [7:0] word;
    logic       word_valid;
    logic       health_fail;
    logic [7:0] div_word;
    logic       div_word_valid;
    logic       div_health_fail;

    int checks = 0;
    int passes = 0;

    random_word_harvester #(
        .WORD_WIDTH     (8),
        .SAMPLE_DIVIDER (1),
        .REPEAT_LIMIT   (8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .metastable  (metastable),
        .word        (word),
        .word_valid  (word_valid),
        .word_ready  (word_ready),
        .health_fail (health_fail)
    );

    random_word_harvester #(
        .WORD_WIDTH     (8),
        .SAMPLE_DIVIDER (4),
        .REPEAT_LIMIT   (32)
    ) dut_div (
        .clk         (clk),
        .rst_n       (rst_n),
        .metastable  (metastable),
        .word        (div_word),
        .word_valid  (div_word_valid),
        .word_ready  (word_ready),
        .health_fail (div_health_fail)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Leaves the bench on a falling edge with reset released; the next rising edge is E1.
    task automatic do_reset();
        @(negedge clk);
        rst_n      = 1'b0;
        metastable = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic push(input logic b);
        metastable = b;
        @(negedge clk);
    endtask

    task automatic push_bits(input logic [31:0] raw, input int n);
        for (int i = n - 1; i >= 0; i--)
            push(raw[i]);
    endtask

    // Divider stream: only positions sampled on ticks carry the 0,1,1,0 pattern, the rest carry its inverse.
    function automatic logic div_raw(input int k);
        int   m;
        logic s;
        m = (k + 3) / 4;
        s = (m >= 1) && ((((m - 1) % 4) == 1) || (((m - 1) % 4) == 2));
        return (((k + 3) % 4) == 0) ? s : ~s;
    endfunction

    task automatic test_reset();
        #1;
        checks++; if (word !== 8'h00) $display("FAIL reset_word: got %h expected 00", word); else passes++;
        checks++; if (word_valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", word_valid); else passes++;
        checks++; if (health_fail !== 1'b0) $display("FAIL reset_health: got %b expected 0", health_fail); else passes++;
        checks++; if (div_word_valid !== 1'b0) $display("FAIL reset_div_valid: got %b expected 0", div_word_valid); else passes++;
    endtask

    task automatic test_alternating();
        do_reset();
        word_ready = 1'b0;
        push_bits(32'h6666, 16);
        push(1'b0);
        push(1'b0);
        checks++; if (word_valid !== 1'b0) $display("FAIL alt_valid_early: got %b expected 0", word_valid); else passes++;
        push(1'b1);
        checks++; if (word_valid !== 1'b1) $display("FAIL alt_valid: got %b expected 1", word_valid); else passes++;
        checks++; if (word !== 8'h55) $display("FAIL alt_word: got %h expected 55", word); else passes++;
        push(1'b1);
        word_ready = 1'b1;
        push(1'b0);
        word_ready = 1'b0;
        checks++; if (word_valid !== 1'b0) $display("FAIL alt_consumed: got %b expected 0", word_valid); else passes++;
    endtask

    task automatic test_discarded();
        do_reset();
        word_ready = 1'b0;
        push_bits(32'h2E2E2E2E, 32);
        push(1'b0);
        push(1'b0);
        checks++; if (word_valid !== 1'b0) $display("FAIL disc_valid_early: got %b expected 0", word_valid); else passes++;
        push(1'b1);
        checks++; if (word_valid !== 1'b1) $display("FAIL disc_valid: got %b expected 1", word_valid); else passes++;
        checks++; if (word !== 8'hFF) $display("FAIL disc_word: got %h expected ff", word); else passes++;
    endtask

    task automatic test_back_to_back();
        do_reset();
        word_ready = 1'b0;
        push_bits(32'h6666, 16);
        push_bits(32'h9966, 16);
        push_bits(32'hAA, 8);
        checks++; if (word_valid !== 1'b1) $display("FAIL bp_held_valid: got %b expected 1", word_valid); else passes++;
        checks++; if (word !== 8'h55) $display("FAIL bp_held_word: got %h expected 55", word); else passes++;
        word_ready = 1'b1;
        push(1'b1);
        word_ready = 1'b0;
        checks++; if (word_valid !== 1'b1) $display("FAIL bp_no_bubble: got %b expected 1", word_valid); else passes++;
        checks++; if (word !== 8'hA5) $display("FAIL bp_second_word: got %h expected a5", word); else passes++;
        push(1'b0);
        checks++; if (word !== 8'hA5) $display("FAIL bp_second_stable: got %h expected a5", word); else passes++;
        word_ready = 1'b1;
        push(1'b1);
        word_ready = 1'b0;
        checks++; if (word_valid !== 1'b0) $display("FAIL bp_drained: got %b expected 0", word_valid); else passes++;
    endtask

    task automatic test_health();
        do_reset();
        word_ready = 1'b0;
        push_bits(32'h6666, 16);
        for (int i = 0; i < 9; i++)
            push(1'b1);
        checks++; if (health_fail !== 1'b0) $display("FAIL hc_before_trip: got %b expected 0", health_fail); else passes++;
        checks++; if (word_valid !== 1'b1) $display("FAIL hc_valid_before: got %b expected 1", word_valid); else passes++;
        push(1'b1);
        checks++; if (health_fail !== 1'b1) $display("FAIL hc_trip: got %b expected 1", health_fail); else passes++;
        checks++; if (word_valid !== 1'b0) $display("FAIL hc_abort_valid: got %b expected 0", word_valid); else passes++;
        word_ready = 1'b1;
        push_bits(32'h66666, 20);
        word_ready = 1'b0;
        checks++; if (health_fail !== 1'b1) $display("FAIL hc_sticky: got %b expected 1", health_fail); else passes++;
        checks++; if (word_valid !== 1'b0) $display("FAIL hc_no_new_word: got %b expected 0", word_valid); else passes++;
        checks++; if (word !== 8'h55) $display("FAIL hc_word_kept: got %h expected 55", word); else passes++;
    endtask

    task automatic test_reset_mid();
        do_reset();
        word_ready = 1'b0;
        push_bits(32'h6666, 16);
        push_bits(32'h55, 7);
        checks++; if (word_valid !== 1'b1) $display("FAIL rm_pre_valid: got %b expected 1", word_valid); else passes++;
        #2 rst_n = 1'b0;
        #1;
        checks++; if (word !== 8'h00) $display("FAIL rm_word: got %h expected 00", word); else passes++;
        checks++; if (word_valid !== 1'b0) $display("FAIL rm_valid: got %b expected 0", word_valid); else passes++;
        checks++; if (health_fail !== 1'b0) $display("FAIL rm_health: got %b expected 0", health_fail); else passes++;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        push_bits(32'h9966, 16);
        push(1'b0);
        push(1'b0);
        checks++; if (word_valid !== 1'b0) $display("FAIL rm_post_early: got %b expected 0", word_valid); else passes++;
        push(1'b1);
        checks++; if (word_valid !== 1'b1) $display("FAIL rm_post_valid: got %b expected 1", word_valid); else passes++;
        checks++; if (word !== 8'hA5) $display("FAIL rm_post_word: got %h expected a5", word); else passes++;
    endtask

    task automatic test_divider();
        do_reset();
        word_ready = 1'b0;
        for (int k = 0; k < 64; k++)
            push(div_raw(k));
        checks++; if (div_word_valid !== 1'b0) $display("FAIL div_valid_early: got %b expected 0", div_word_valid); else passes++;
        push(div_raw(64));
        checks++; if (div_word_valid !== 1'b1) $display("FAIL div_valid: got %b expected 1", div_word_valid); else passes++;
        checks++; if (div_word !== 8'h55) $display("FAIL div_word: got %h expected 55", div_word); else passes++;
        checks++; if (div_health_fail !== 1'b0) $display("FAIL div_health: got %b expected 0", div_health_fail); else passes++;
    endtask

    initial begin
        rst_n      = 1'b0;
        metastable = 1'b0;
        word_ready = 1'b0;
        test_reset();
        test_alternating();
        test_discarded();
        test_back_to_back();
        test_health();
        test_reset_mid();
        test_divider();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
